// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and controller for a word-addressed
// 32-bit data memory with asynchronous read and synchronous write.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mX_req/we/addr/wdata/be  master X request (X = 0 core LSU, 1 debug/DMA)
//   mX_gnt                   combinational grant, same cycle as the request
//   mX_rvalid/rdata/err      registered response, one cycle after the grant
//   dm_en/addr/wdata         memory write enable, byte address, merged word
//   dm_rdata                 asynchronous memory read data
//
// Byte-strobe stores are done as a single-cycle read-modify-write: the
// asynchronous read of the granted word is merged with the store bytes and
// written back on the same edge.
module dmem_arbiter #(
   parameter int unsigned ADDR_LIMIT = 4000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_be,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_be,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        dm_en,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata
);

   typedef enum logic {
      PRIO_M0 = 1'b0,
      PRIO_M1 = 1'b1
   } prio_t;

   prio_t       prio;
   logic        gnt0;
   logic        gnt1;
   logic        any_gnt;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_be;
   logic        bad;
   logic [31:0] merged;

   always_comb begin
      // The favoured master only matters when both are requesting.
      gnt0    = m0_req & (~m1_req | (prio == PRIO_M0));
      gnt1    = m1_req & (~m0_req | (prio == PRIO_M1));
      any_gnt = gnt0 | gnt1;

      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      if (gnt1) begin
         sel_we    = m1_we;
         sel_addr  = m1_addr;
         sel_wdata = m1_wdata;
         sel_be    = m1_be;
      end else if (gnt0) begin
         sel_we    = m0_we;
         sel_addr  = m0_addr;
         sel_wdata = m0_wdata;
         sel_be    = m0_be;
      end

      bad = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);

      // Unselected bytes keep the current memory contents.
      merged = dm_rdata;
      for (int unsigned i = 0; i < 4; i++) begin
         if (sel_be[i]) begin
            merged[8*i +: 8] = sel_wdata[8*i +: 8];
         end
      end

      dm_en    = any_gnt & sel_we & ~bad & (sel_be != 4'b0000);
      dm_addr  = any_gnt ? sel_addr : '0;
      dm_wdata = any_gnt ? merged : '0;
   end

   assign m0_gnt = gnt0;
   assign m1_gnt = gnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio      <= PRIO_M0;
         m0_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m0_err    <= 1'b0;
         m1_rvalid <= 1'b0;
         m1_rdata  <= '0;
         m1_err    <= 1'b0;
      end else begin
         m0_rvalid <= gnt0;
         m1_rvalid <= gnt1;
         if (gnt0) begin
            m0_err   <= bad;
            m0_rdata <= (~sel_we & ~bad) ? dm_rdata : '0;
            prio     <= PRIO_M1;
         end
         if (gnt1) begin
            m1_err   <= bad;
            m1_rdata <= (~sel_we & ~bad) ? dm_rdata : '0;
            prio     <= PRIO_M0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural memory sits on the
// dm_* port, and a reference model (winner choice, word array, expected
// response registers) predicts every grant, write and response.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_be;
   logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_be;
   logic        dm_en;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;

   logic [31:0] mem [0:1023];

   dmem_arbiter #(.ADDR_LIMIT(4000)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .m1_err(m1_err),
      .dm_en(dm_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: asynchronous read, synchronous write.
   assign dm_rdata = (dm_addr < 32'd4096) ? mem[dm_addr[11:2]] : 32'hDEAD_BEEF;
   always @(posedge clk) if (dm_en) mem[dm_addr[11:2]] <= dm_wdata;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   logic [31:0] ref_mem [0:1023];
   int          last_win;          // master granted most recently (1 after reset)
   int          nx_win;
   bit   [1:0]  e_gnt;             // [0] = m0
   bit          e_en;
   logic [31:0] e_addr, e_wdata;
   bit   [1:0]  e_rv, e_er, nx_rv, nx_er;
   logic [31:0] e_rd [2];
   logic [31:0] nx_rd [2];
   bit          pw;
   int          pw_idx;
   logic [31:0] pw_data;

   task automatic model_reset();
      last_win = 1;
      nx_win   = 1;
      e_rv     = '0;
      e_er     = '0;
      e_rd[0]  = '0;
      e_rd[1]  = '0;
      pw       = 0;
   endtask

   // Drive one cycle of requests at the falling edge and predict its effect.
   task automatic drive(input bit r0, input bit w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic [3:0] b0,
                        input bit r1, input bit w1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic [3:0] b1);
      int          win;
      bit          we, bad;
      logic [31:0] a, d, word;
      logic [3:0]  b;
      @(negedge clk);
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_be = b0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_be = b1;
      if (r0 && r1)  win = (last_win == 0) ? 1 : 0;
      else if (r0)   win = 0;
      else if (r1)   win = 1;
      else           win = -1;
      nx_rv = '0; nx_er = e_er; nx_rd = e_rd;
      e_gnt = '0; e_en = 0; e_addr = '0; e_wdata = '0; pw = 0; nx_win = last_win;
      if (win >= 0) begin
         we = (win == 1) ? w1 : w0;
         a  = (win == 1) ? a1 : a0;
         d  = (win == 1) ? d1 : d0;
         b  = (win == 1) ? b1 : b0;
         bad  = (a % 4 != 0) || (a >= 4000);
         word = ref_mem[a[11:2]];
         e_gnt[win]  = 1;
         e_addr      = a;
         nx_win      = win;
         nx_rv[win]  = 1;
         nx_er[win]  = bad;
         nx_rd[win]  = (!we && !bad) ? word : 32'd0;
         if (we && !bad && b != 0) begin
            for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
            e_en = 1; e_wdata = word; pw = 1; pw_idx = int'(a / 4); pw_data = word;
         end
      end
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance through the rising edge and commit the prediction.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (pw) ref_mem[pw_idx] = pw_data;
         last_win = nx_win;
         e_rv = nx_rv; e_er = nx_er; e_rd = nx_rd;
      end
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata, m0_gnt, m1_gnt, dm_en} !== '0) begin
         errors++;
         $display("FAIL reset_state: got m0 %b/%b/%h m1 %b/%b/%h gnt %b%b en %b, want all zero",
                  m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata, m0_gnt, m1_gnt, dm_en);
      end
      @(negedge clk); rst = 1'b0;
      drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== ref_mem[16]) begin
         errors++;
         $display("FAIL reset_preload: got rvalid=%b rdata=%h want 1 %h", m0_rvalid, m0_rdata, ref_mem[16]);
      end
      // Reset pulsed between edges must clear the response immediately.
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_async: got rvalid=%b rdata=%h want 0 0", m0_rvalid, m0_rdata);
      end
      // Load granted while reset is high: its response is dropped.
      drive(1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_dropped: got rvalid=%b rdata=%h want 0 0", m0_rvalid, m0_rdata);
      end
      @(negedge clk); rst = 1'b0;
      idle(); tick();
      checks++;
      if (m0_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_late_resp: got rvalid=%b want 0", m0_rvalid);
      end
   endtask

   task automatic test_byte_merge();
      drive(1, 1, 32'h10, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 32'h10, 32'h11223344, 4'b0101, 0, 0, 0, 0, 0);
      checks++;
      if (dm_en !== 1'b1 || dm_wdata !== 32'hAA22CC44) begin
         errors++;
         $display("FAIL merge_write: got en=%b wdata=%h want 1 aa22cc44", dm_en, dm_wdata);
      end
      tick();
      drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL merge_gnt: got gnt=%b rvalid(prev store)=%b want 1 1", m0_gnt, m0_rvalid);
      end
      tick();
      checks++;
      if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hAA22CC44) begin
         errors++;
         $display("FAIL merge_load: got rvalid=%b err=%b rdata=%h want 1 0 aa22cc44",
                  m0_rvalid, m0_err, m0_rdata);
      end
      idle(); tick();
      checks++;
      if (m0_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rvalid_pulse: got rvalid=%b want 0", m0_rvalid);
      end
   endtask

   task automatic test_contention();
      @(negedge clk); rst = 1'b1; #1; model_reset();
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 32'h100 + 4*i, $urandom, 4'hF, 1, 1, 32'h200 + 4*i, $urandom, 4'hF);
         checks++;
         if ({m1_gnt, m0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10) || dm_en !== 1'b1 ||
             dm_addr !== e_addr || dm_wdata !== e_wdata) begin
            errors++;
            $display("FAIL contention_%0d: got gnt(m1m0)=%b%b en=%b addr=%h want %0d-only en=1 addr=%h",
                     i, m1_gnt, m0_gnt, dm_en, dm_addr, i % 2, e_addr);
         end
         tick();
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 32'h200 + 4*i, 0, 0);
         checks++;
         if ({m1_gnt, m0_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL single_m1_%0d: got gnt(m1m0)=%b%b want 10", i, m1_gnt, m0_gnt);
         end
         tick();
         checks++;
         if (m1_rvalid !== 1'b1 || m1_rdata !== e_rd[1]) begin
            errors++;
            $display("FAIL single_resp_%0d: got %b %h want 1 %h", i, m1_rvalid, m1_rdata, e_rd[1]);
         end
      end
      // Last grant went to m1, so m0 wins the next contention, then m1.
      drive(1, 0, 32'h0, 0, 0, 1, 0, 32'h4, 0, 0);
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin
         errors++;
         $display("FAIL prio_after_m1: got gnt(m1m0)=%b%b want 01", m1_gnt, m0_gnt);
      end
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0);
      tick();
      drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 32'h0, 0, 0, 1, 0, 32'h4, 0, 0);
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL prio_after_m0: got gnt(m1m0)=%b%b want 10", m1_gnt, m0_gnt);
      end
      tick();
      idle(); tick();
   endtask

   task automatic test_errors();
      drive(1, 1, 32'h13, 32'h0BAD_0BAD, 4'hF, 0, 0, 0, 0, 0);
      checks++;
      if (m0_gnt !== 1'b1 || dm_en !== 1'b0) begin
         errors++;
         $display("FAIL err_misaligned_en: got gnt=%b en=%b want 1 0", m0_gnt, dm_en);
      end
      tick();
      checks++;
      if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'd0) begin
         errors++;
         $display("FAIL err_misaligned: got %b %b %h want 1 1 0", m0_rvalid, m0_err, m0_rdata);
      end
      drive(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0); tick();
      checks++;
      if (m1_rdata !== 32'hAA22CC44 || m1_err !== 1'b0) begin
         errors++;
         $display("FAIL err_mem_intact: got %h err=%b want aa22cc44 0", m1_rdata, m1_err);
      end
      drive(0, 0, 0, 0, 0, 1, 0, 32'd4000, 0, 0); tick();
      checks++;
      if (m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'd0) begin
         errors++;
         $display("FAIL err_limit: got %b %b %h want 1 1 0", m1_rvalid, m1_err, m1_rdata);
      end
      drive(0, 0, 0, 0, 0, 1, 0, 32'd3996, 0, 0); tick();
      checks++;
      if (m1_rvalid !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== ref_mem[999]) begin
         errors++;
         $display("FAIL err_last_word: got %b %b %h want 1 0 %h", m1_rvalid, m1_err, m1_rdata, ref_mem[999]);
      end
      idle(); tick();
   endtask

   task automatic test_empty_strobe();
      drive(1, 1, 32'h20, 32'h5, 4'hF, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0, 0);
      checks++;
      if (dm_en !== 1'b0) begin
         errors++;
         $display("FAIL empty_be_en: got en=%b want 0", dm_en);
      end
      tick();
      checks++;
      if (m0_rvalid !== 1'b1 || m0_err !== 1'b0) begin
         errors++;
         $display("FAIL empty_be_ack: got rvalid=%b err=%b want 1 0", m0_rvalid, m0_err);
      end
      drive(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0); tick();
      checks++;
      if (m0_rdata !== 32'h5) begin
         errors++;
         $display("FAIL empty_be_load: got %h want 00000005", m0_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      v = $urandom;
      drive(1, 1, 32'h30, v, 4'hF, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 1, 0, 32'h30, 0, 0); tick();
      checks++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== v) begin
         errors++;
         $display("FAIL back_to_back: got %b %h want 1 %h", m1_rvalid, m1_rdata, v);
      end
      idle(); tick();
   endtask

   task automatic test_random();
      bit          pend [2];
      bit          pwe  [2];
      logic [31:0] pa   [2];
      logic [31:0] pd   [2];
      logic [3:0]  pb   [2];
      for (int k = 0; k < 2; k++) pend[k] = 0;
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (!pend[k] && $urandom_range(0, 3) != 0) begin
               pend[k] = 1;
               pwe[k]  = 1'($urandom_range(0, 1));
               pb[k]   = 4'($urandom);
               pd[k]   = $urandom;
               case ($urandom_range(0, 9))
                  0:       pa[k] = $urandom;
                  1:       pa[k] = {20'd0, 12'($urandom)};
                  2:       pa[k] = 32'd3996 + 32'($urandom_range(0, 3)) * 4;
                  default: pa[k] = 32'($urandom_range(0, 31)) * 4;
               endcase
            end
         end
         drive(pend[0], pwe[0], pa[0], pd[0], pb[0], pend[1], pwe[1], pa[1], pd[1], pb[1]);
         checks++;
         if ({m1_gnt, m0_gnt} !== e_gnt || dm_en !== e_en || dm_addr !== e_addr ||
             (e_en && dm_wdata !== e_wdata) || (e_gnt == 2'b00 && dm_wdata !== 32'd0)) begin
            errors++;
            $display("FAIL rand_mem_%0d: got gnt=%b%b en=%b addr=%h wdata=%h want gnt=%b en=%b addr=%h wdata=%h",
                     n, m1_gnt, m0_gnt, dm_en, dm_addr, dm_wdata, e_gnt, e_en, e_addr, e_wdata);
         end
         if (e_gnt[0]) pend[0] = 0;
         if (e_gnt[1]) pend[1] = 0;
         tick();
         checks++;
         if ({m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata} !==
             {e_rv[0], e_er[0], e_rd[0], e_rv[1], e_er[1], e_rd[1]}) begin
            errors++;
            $display("FAIL rand_resp_%0d: got m0 %b/%b/%h m1 %b/%b/%h want m0 %b/%b/%h m1 %b/%b/%h",
                     n, m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata,
                     e_rv[0], e_er[0], e_rd[0], e_rv[1], e_er[1], e_rd[1]);
         end
      end
      idle(); tick();
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
      for (int i = 0; i < 1024; i++) begin
         logic [31:0] v;
         v = $urandom;
         mem[i] = v;
         ref_mem[i] = v;
      end
      model_reset();
      @(negedge clk);
      test_reset();
      test_byte_merge();
      test_contention();
      test_single();
      test_errors();
      test_empty_strobe();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
